// File: rtl/vote_result_tx.sv
// Vote result readout: snapshots four tallies and sends them as a UART frame
// (A5, counts, checksum) while also registering the winner and tie flag.
module vote_result_tx #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       mode,
  input  logic       send_req,
  input  logic [7:0] cand1_count,
  input  logic [7:0] cand2_count,
  input  logic [7:0] cand3_count,
  input  logic [7:0] cand4_count,
  output logic       tx_serial,
  output logic       busy,
  output logic       done,
  output logic [1:0] winner,
  output logic       tie,
  output logic       winner_valid
);

  localparam int BW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [7:0] HEADER = 8'hA5;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t          state, state_nx;
  logic [BW-1:0]   baud, baud_nx;
  logic [2:0]      bit_idx, bit_nx;
  logic [2:0]      byte_idx, byte_nx;
  logic            done_nx;
  logic            calc;
  logic [3:0][7:0] snap;
  logic [7:0]      checksum;
  logic [7:0]      cur_byte;
  logic            accept;
  logic            tick;
  logic [1:0]      win_c;
  logic            tie_c;
  logic [7:0]      max_c;
  logic [2:0]      hits;

  assign accept   = (state == IDLE) && mode && send_req;
  assign tick     = (baud == BAUD_LAST);
  assign busy     = (state != IDLE);
  assign checksum = snap[0] + snap[1] + snap[2] + snap[3];

  always_comb begin
    case (byte_idx)
      3'd0:    cur_byte = HEADER;
      3'd1:    cur_byte = snap[0];
      3'd2:    cur_byte = snap[1];
      3'd3:    cur_byte = snap[2];
      3'd4:    cur_byte = snap[3];
      default: cur_byte = checksum;
    endcase
  end

  always_comb begin
    tx_serial = 1'b1;
    case (state)
      START:   tx_serial = 1'b0;
      DATA:    tx_serial = cur_byte[bit_idx];
      default: tx_serial = 1'b1;
    endcase
  end

  always_comb begin
    state_nx = state;
    baud_nx  = baud;
    bit_nx   = bit_idx;
    byte_nx  = byte_idx;
    done_nx  = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          state_nx = START;
          baud_nx  = '0;
          bit_nx   = '0;
          byte_nx  = '0;
        end
      end
      START: begin
        if (tick) begin
          state_nx = DATA;
          baud_nx  = '0;
          bit_nx   = '0;
        end else begin
          baud_nx = baud + 1'b1;
        end
      end
      DATA: begin
        if (tick) begin
          baud_nx = '0;
          if (bit_idx == 3'd7) state_nx = STOP;
          else bit_nx = bit_idx + 3'd1;
        end else begin
          baud_nx = baud + 1'b1;
        end
      end
      STOP: begin
        if (tick) begin
          baud_nx = '0;
          if (byte_idx == 3'd5) begin
            state_nx = IDLE;
            done_nx  = 1'b1;
          end else begin
            state_nx = START;
            byte_nx  = byte_idx + 3'd1;
          end
        end else begin
          baud_nx = baud + 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Lowest index wins; a shared maximum (including all zero) flags a tie.
  always_comb begin
    max_c = snap[0];
    for (int i = 1; i < 4; i++) begin
      if (snap[i] > max_c) max_c = snap[i];
    end
    win_c = 2'd0;
    hits  = 3'd0;
    for (int i = 3; i >= 0; i--) begin
      if (snap[i] == max_c) begin
        win_c = 2'(i);
        hits  = hits + 3'd1;
      end
    end
    tie_c = (hits > 3'd1);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= IDLE;
      baud         <= '0;
      bit_idx      <= '0;
      byte_idx     <= '0;
      done         <= 1'b0;
      calc         <= 1'b0;
      snap         <= '0;
      winner       <= 2'd0;
      tie          <= 1'b0;
      winner_valid <= 1'b0;
    end else begin
      state    <= state_nx;
      baud     <= baud_nx;
      bit_idx  <= bit_nx;
      byte_idx <= byte_nx;
      done     <= done_nx;
      calc     <= accept;
      if (accept) begin
        snap <= {cand4_count, cand3_count, cand2_count, cand1_count};
      end
      if (calc) begin
        winner       <= win_c;
        tie          <= tie_c;
        winner_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_vote_result_tx.sv
// Randomised bench for vote_result_tx: decodes frames off the serial line and
// compares against a frame/winner model computed from the tallies.
module tb_vote_result_tx;

  localparam int CPB = 4;

  logic       clock;
  logic       reset;
  logic       mode;
  logic       send_req;
  logic [7:0] c1, c2, c3, c4;
  logic       tx_serial;
  logic       busy;
  logic       done;
  logic [1:0] winner;
  logic       tie;
  logic       winner_valid;

  int total = 0;
  int bad = 0;

  logic        raw [0:1023];
  logic [47:0] cap_frame;
  int          cap_busy;
  logic        cap_done;
  bit          cap_shape;
  logic [1:0]  cap_w;
  logic        cap_t;
  logic        cap_v0;
  logic        cap_v1;

  vote_result_tx #(.CLKS_PER_BIT(CPB)) dut (
    .clock(clock),
    .reset(reset),
    .mode(mode),
    .send_req(send_req),
    .cand1_count(c1),
    .cand2_count(c2),
    .cand3_count(c3),
    .cand4_count(c4),
    .tx_serial(tx_serial),
    .busy(busy),
    .done(done),
    .winner(winner),
    .tie(tie),
    .winner_valid(winner_valid)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [47:0] exp_frame(input logic [7:0] a, b, c, d);
    int s;
    s = (int'(a) + int'(b) + int'(c) + int'(d)) % 256;
    return {8'hA5, a, b, c, d, 8'(s)};
  endfunction

  // returns {tie, winner}
  function automatic logic [2:0] exp_win(input logic [7:0] a, b, c, d);
    int v[4];
    int best;
    int cnt;
    v[0] = int'(a); v[1] = int'(b); v[2] = int'(c); v[3] = int'(d);
    best = 0;
    for (int i = 1; i < 4; i++) if (v[i] > v[best]) best = i;
    cnt = 0;
    for (int i = 0; i < 4; i++) if (v[i] == v[best]) cnt++;
    return {cnt > 1, 2'(best)};
  endfunction

  task automatic tick1();
    @(posedge clock);
    #1;
  endtask

  task automatic set_counts(input logic [7:0] a, b, c, d);
    c1 = a; c2 = b; c3 = c; c4 = d;
  endtask

  // Records one frame; caller has just raised send_req in an idle cycle.
  task automatic capture(input bit hold, input int poke_at);
    int n;
    int base;
    logic v;
    n = 0;
    tick1();
    if (!hold) send_req = 1'b0;
    cap_v0 = winner_valid;
    cap_w = 2'bxx; cap_t = 1'bx; cap_v1 = 1'bx;
    while (busy && n < 1000) begin
      if (n == 1) begin
        cap_w = winner; cap_t = tie; cap_v1 = winner_valid;
      end
      if (poke_at >= 0 && n == poke_at) begin
        set_counts(8'hFF, 8'hFF, 8'hFF, 8'hFF);
        send_req = 1'b1;
      end
      if (poke_at >= 0 && n == poke_at + 1) begin
        send_req = 1'b0;
        mode = 1'b0;
      end
      raw[n] = tx_serial;
      n++;
      tick1();
    end
    cap_busy = n;
    cap_done = done;
    cap_shape = 1'b1;
    cap_frame = '0;
    for (int k = 0; k < 6; k++) begin
      for (int j = 0; j < 10; j++) begin
        base = (k * 10 + j) * CPB;
        if (base + CPB > n) begin
          cap_shape = 1'b0;
        end else begin
          v = raw[base + CPB / 2];
          for (int c = 0; c < CPB; c++) if (raw[base + c] !== v) cap_shape = 1'b0;
          if (j == 0 && v !== 1'b0) cap_shape = 1'b0;
          if (j == 9 && v !== 1'b1) cap_shape = 1'b0;
          if (j >= 1 && j <= 8) cap_frame[(5 - k) * 8 + (j - 1)] = v;
        end
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) tick1();
    total++;
    if (tx_serial !== 1'b1) begin bad++; $display("FAIL rst_tx got %b want 1", tx_serial); end
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got %b want 0", busy); end
    total++;
    if (done !== 1'b0) begin bad++; $display("FAIL rst_done got %b want 0", done); end
    total++;
    if ({winner, tie, winner_valid} !== 4'b0000)
      begin bad++; $display("FAIL rst_win got %b want 0000", {winner, tie, winner_valid}); end
    reset = 1'b0;
    tick1();
  endtask

  task automatic test_mode0();
    int errs;
    errs = 0;
    mode = 1'b0;
    send_req = 1'b1;
    set_counts(8'd5, 8'd6, 8'd7, 8'd8);
    for (int i = 0; i < 20; i++) begin
      tick1();
      if (tx_serial !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || winner_valid !== 1'b0)
        errs++;
    end
    total++;
    if (errs != 0) begin bad++; $display("FAIL mode0_idle got %0d bad cycles want 0", errs); end
    send_req = 1'b0;
    mode = 1'b1;
    tick1();
  endtask

  task automatic test_basic();
    set_counts(8'd3, 8'd7, 8'd7, 8'd1);
    send_req = 1'b1;
    capture(1'b0, -1);
    total++;
    if (cap_frame !== 48'hA5_03_07_07_01_12)
      begin bad++; $display("FAIL basic_frame got %h want a50307070112", cap_frame); end
    total++;
    if (!cap_shape) begin bad++; $display("FAIL basic_shape got 0 want 1"); end
    total++;
    if (cap_busy != 60 * CPB) begin bad++; $display("FAIL basic_busy got %0d want %0d", cap_busy, 60 * CPB); end
    total++;
    if (cap_done !== 1'b1 || tx_serial !== 1'b1)
      begin bad++; $display("FAIL basic_done got %b%b want 11", cap_done, tx_serial); end
    total++;
    if (cap_v0 !== 1'b0) begin bad++; $display("FAIL basic_v0 got %b want 0", cap_v0); end
    total++;
    if ({cap_t, cap_w, cap_v1} !== {1'b1, 2'd1, 1'b1})
      begin bad++; $display("FAIL basic_win got %b want 1011", {cap_t, cap_w, cap_v1}); end
    tick1();
    total++;
    if (done !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL basic_pulse got %b%b want 00", done, busy); end
  endtask

  task automatic test_wrap();
    set_counts(8'h80, 8'h90, 8'h00, 8'h00);
    send_req = 1'b1;
    capture(1'b0, -1);
    total++;
    if (cap_frame !== 48'hA5_80_90_00_00_10 || !cap_shape)
      begin bad++; $display("FAIL wrap_frame got %h want a58090000010", cap_frame); end
    total++;
    if ({cap_t, cap_w} !== 3'b001) begin bad++; $display("FAIL wrap_win got %b want 001", {cap_t, cap_w}); end
    tick1();
  endtask

  task automatic test_isolation();
    int errs;
    set_counts(8'd1, 8'd2, 8'd3, 8'd4);
    send_req = 1'b1;
    capture(1'b0, 50);
    total++;
    if (cap_frame !== 48'hA5_01_02_03_04_0A || !cap_shape)
      begin bad++; $display("FAIL iso_frame got %h want a5010203040a", cap_frame); end
    total++;
    if (cap_busy != 60 * CPB || cap_done !== 1'b1)
      begin bad++; $display("FAIL iso_len got %0d/%b want %0d/1", cap_busy, cap_done, 60 * CPB); end
    errs = 0;
    for (int i = 0; i < 8; i++) begin
      tick1();
      if (busy !== 1'b0 || tx_serial !== 1'b1) errs++;
    end
    total++;
    if (errs != 0) begin bad++; $display("FAIL iso_no_refire got %0d busy cycles want 0", errs); end
    total++;
    if ({tie, winner} !== 3'b011) begin bad++; $display("FAIL iso_win got %b want 011", {tie, winner}); end
    mode = 1'b1;
  endtask

  task automatic test_reset_mid();
    logic [7:0] a, b, c, d;
    int errs;
    set_counts(8'd9, 8'd8, 8'd7, 8'd6);
    send_req = 1'b1;
    tick1();
    send_req = 1'b0;
    for (int i = 0; i < 100; i++) tick1();
    reset = 1'b1;
    tick1();
    total++;
    if ({tx_serial, busy, done, winner_valid} !== 4'b1000)
      begin bad++; $display("FAIL midrst got %b want 1000", {tx_serial, busy, done, winner_valid}); end
    reset = 1'b0;
    errs = 0;
    for (int i = 0; i < 300; i++) begin
      tick1();
      if (done !== 1'b0 || busy !== 1'b0) errs++;
    end
    total++;
    if (errs != 0) begin bad++; $display("FAIL midrst_quiet got %0d cycles want 0", errs); end
    a = 8'($urandom); b = 8'($urandom); c = 8'($urandom); d = 8'($urandom);
    set_counts(a, b, c, d);
    send_req = 1'b1;
    capture(1'b0, -1);
    total++;
    if (cap_frame !== exp_frame(a, b, c, d) || !cap_shape || cap_done !== 1'b1)
      begin bad++; $display("FAIL midrst_frame got %h want %h", cap_frame, exp_frame(a, b, c, d)); end
    tick1();
  endtask

  task automatic test_back_to_back();
    set_counts(8'd0, 8'd0, 8'd0, 8'd0);
    send_req = 1'b1;
    for (int f = 0; f < 3; f++) begin
      capture(1'b1, -1);
      total++;
      if (cap_frame !== 48'hA5_00_00_00_00_00 || !cap_shape || cap_busy != 60 * CPB)
        begin bad++; $display("FAIL b2b_frame%0d got %h len %0d", f, cap_frame, cap_busy); end
      total++;
      if (cap_done !== 1'b1 || busy !== 1'b0)
        begin bad++; $display("FAIL b2b_done%0d got %b%b want 10", f, cap_done, busy); end
      total++;
      if ({cap_t, cap_w} !== 3'b100) begin bad++; $display("FAIL b2b_win%0d got %b want 100", f, {cap_t, cap_w}); end
    end
    send_req = 1'b0;
    tick1();
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL b2b_stop got %b want 0", busy); end
  endtask

  task automatic test_random();
    logic [7:0] a, b, c, d;
    for (int it = 0; it < 6; it++) begin
      if (it % 2 == 0) begin
        a = 8'($urandom_range(0, 3)); b = 8'($urandom_range(0, 3));
        c = 8'($urandom_range(0, 3)); d = 8'($urandom_range(0, 3));
      end else begin
        a = 8'($urandom); b = 8'($urandom); c = 8'($urandom); d = 8'($urandom);
      end
      set_counts(a, b, c, d);
      send_req = 1'b1;
      capture(1'b0, -1);
      total++;
      if (cap_frame !== exp_frame(a, b, c, d) || !cap_shape)
        begin bad++; $display("FAIL rnd_frame%0d got %h want %h", it, cap_frame, exp_frame(a, b, c, d)); end
      total++;
      if (cap_busy != 60 * CPB || cap_done !== 1'b1)
        begin bad++; $display("FAIL rnd_len%0d got %0d/%b want %0d/1", it, cap_busy, cap_done, 60 * CPB); end
      total++;
      if ({cap_t, cap_w, cap_v1} !== {exp_win(a, b, c, d), 1'b1})
        begin bad++; $display("FAIL rnd_win%0d got %b want %b1", it, {cap_t, cap_w, cap_v1}, exp_win(a, b, c, d)); end
      repeat ($urandom_range(1, 3)) tick1();
    end
  endtask

  initial begin
    reset = 1'b1;
    mode = 1'b0;
    send_req = 1'b0;
    set_counts(8'd0, 8'd0, 8'd0, 8'd0);
    test_reset();
    test_mode0();
    test_basic();
    test_wrap();
    test_isolation();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vote_result_tx.md
Name: vote_result_tx

Overview:
Readout end of the vote-logging path. In result mode, on request, it snapshots the four 8-bit candidate tallies produced by the vote logger and serialises them as a UART-style frame. The frame is: header, four counts, checksum. From the same snapshot it also derives the winner index and a tie flag. It sits between the tally counters and the board's serial/debug output.

Parameters:
CLKS_PER_BIT, 4, clock cycles each serial bit is held (must be >= 2)

Ports:
clock  input  1  system clock
reset  input  1  synchronous, active-high reset
mode  input  1  0 = voting, 1 = result; requests are honoured only when 1
send_req  input  1  level/pulse request to transmit results
cand1_count  input  8  tally for candidate 1
cand2_count  input  8  tally for candidate 2
cand3_count  input  8  tally for candidate 3
cand4_count  input  8  tally for candidate 4
tx_serial  output  1  serial line, idle high
busy  output  1  high while a frame is in progress
done  output  1  one-cycle pulse at frame completion
winner  output  2  index of max tally (0 = cand1 … 3 = cand4)
tie  output  1  max tally shared by two or more candidates
winner_valid  output  1  winner/tie hold a computed result

Behaviour:
- Reset values (all at the reset edge, including mid-frame): tx_serial=1, busy=0, done=0, winner=0, tie=0, winner_valid=0. Internal state returns to IDLE. No done pulse is generated for an aborted frame.
- Acceptance: at an edge where state=IDLE, mode=1 and send_req=1:
  - all four counts are latched into a snapshot register;
  - busy=1 from the next cycle.
- send_req is ignored while busy=1 or while mode=0. A held send_req re-triggers one cycle after done.
- Frame: 6 bytes in order 0xA5, cand1, cand2, cand3, cand4, checksum.
  - checksum = (cand1+cand2+cand3+cand4) mod 256, taken from the snapshot. It is 8-bit wrap-around and excludes the header.
- Byte format:
  - start bit 0;
  - 8 data bits, LSB first;
  - stop bit 1.
  - Each bit is driven for exactly CLKS_PER_BIT cycles. Bytes are back-to-back with no idle gap.
- FSM states: IDLE → START → DATA → STOP.
  - STOP → START if bytes remain, else → IDLE.
  - A bit counter (0..7) runs in DATA; a byte index (0..5) tracks the frame.
  - A baud counter (0..CLKS_PER_BIT-1) advances the FSM on terminal count.
- Latency:
  - First start-bit cycle is the cycle immediately after acceptance.
  - busy is high for exactly 60*CLKS_PER_BIT cycles.
  - done=1 for one cycle, in the cycle after the final stop bit's last cycle. busy=0 in that same cycle. tx_serial stays 1.
- Snapshot isolation: changes on the count inputs, or mode going to 0, during a frame do not alter the transmitted bytes. The frame always completes.
- Winner/tie, computed from the snapshot and registered:
  - valid from the second cycle after acceptance; winner_valid=1 from then until reset;
  - winner = lowest index holding the max value;
  - tie=1 iff at least two candidates equal the max. All-zero counts give winner=0, tie=1.
  - Values hold until the next accepted request.

Test Plan:
- Reset, CLKS_PER_BIT=4; mode=1; counts 3,7,7,1; pulse send_req → bytes A5,03,07,07,01,12 decoded LSB-first. busy high for 240 cycles, then done pulse for one cycle. winner=1, tie=1, winner_valid=1.
- Counts 0x80,0x90,0x00,0x00 → checksum byte 0x10 (wrap-around); winner=1, tie=0.
- mode=0 with send_req=1 for 20 cycles → tx_serial stays 1, busy=0, no done, winner_valid=0.
- Frame in progress with counts 1,2,3,4; at cycle 50 change counts to FF,FF,FF,FF and pulse send_req → the frame still carries 01,02,03,04,0A and no second frame starts. winner=3, tie=0.
- Assert reset at cycle 100 of a frame → next cycle tx_serial=1, busy=0. done never pulses. A new request afterwards yields a complete, correct frame.
- All counts 0 with send_req held high → back-to-back frames A5,00,00,00,00,00 separated by one done cycle. winner=0, tie=1.
